// File: rtl/multicycle_core.sv
// Multi-cycle RV64I/RV32I subset core: FETCH/DECODE/EXEC/MEM/WB around one ALU and one memory port.
// Define MULTICYCLE_CORE_BNE_EN to make bne legal; otherwise bne halts like any illegal encoding.
module multicycle_core #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instret,
  output logic            halt
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  localparam logic [2:0] MEM_F3 = (XLEN == 64) ? 3'b011 : 3'b010;

  state_t state, next_state;

  logic [31:0]     ir;
  logic [XLEN-1:0] a_reg, b_reg, imm_reg, alu_out, mdr;
  logic [XLEN-1:0] rf [32];

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  logic is_rtype, is_addi, is_load, is_store, is_beq, is_bne, is_branch, legal;

  assign is_rtype = (opcode == 7'b0110011) &&
                    (((funct3 == 3'b000) && ((funct7 == 7'b0000000) || (funct7 == 7'b0100000))) ||
                     ((funct3 == 3'b111) && (funct7 == 7'b0000000)) ||
                     ((funct3 == 3'b110) && (funct7 == 7'b0000000)));
  assign is_addi  = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_load  = (opcode == 7'b0000011) && (funct3 == MEM_F3);
  assign is_store = (opcode == 7'b0100011) && (funct3 == MEM_F3);
  assign is_beq   = (opcode == 7'b1100011) && (funct3 == 3'b000);
`ifdef MULTICYCLE_CORE_BNE_EN
  assign is_bne   = (opcode == 7'b1100011) && (funct3 == 3'b001);
`else
  assign is_bne   = 1'b0;
`endif
  assign is_branch = is_beq || is_bne;
  assign legal     = is_rtype || is_addi || is_load || is_store || is_branch;

  logic [XLEN-1:0] imm_sel, rf_a, rf_b, op_a, op_b, alu_result, pc_plus4;
  logic            taken, misaligned;

  always_comb begin
    imm_sel = {{(XLEN-12){ir[31]}}, ir[31:20]};
    if (is_store)
      imm_sel = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
    else if (is_branch)
      imm_sel = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  end

  assign rf_a = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rf_b = (rs2 == 5'd0) ? '0 : rf[rs2];

  // The single ALU also forms branch targets, so its A operand switches to pc for branches.
  always_comb begin
    op_a       = is_branch ? pc : a_reg;
    op_b       = is_rtype ? b_reg : imm_reg;
    alu_result = op_a + op_b;
    if (is_rtype) begin
      case (funct3)
        3'b000:  alu_result = funct7[5] ? (op_a - op_b) : (op_a + op_b);
        3'b111:  alu_result = op_a & op_b;
        3'b110:  alu_result = op_a | op_b;
        default: alu_result = op_a + op_b;
      endcase
    end
  end

  assign pc_plus4   = pc + XLEN'(4);
  assign taken      = is_beq ? (a_reg == b_reg) : (is_bne && (a_reg != b_reg));
  assign misaligned = alu_result[1:0] != 2'b00;
  assign halt       = (state == S_HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: next_state = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_branch)
          next_state = (taken && misaligned) ? S_HALT : S_FETCH;
        else if (is_load || is_store)
          next_state = S_MEM;
        else
          next_state = S_WB;
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = is_store;
        mem_addr  = alu_out;
        mem_wdata = is_store ? b_reg : '0;
        if (mem_ready) next_state = is_load ? S_WB : S_FETCH;
      end
      S_WB:    next_state = S_FETCH;
      S_HALT:  next_state = S_HALT;
      default: next_state = S_HALT;
    endcase
    // Reset gates the bus directly so a pending request vanishes without waiting for a clock.
    if (!reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      instret <= '0;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      imm_reg <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_FETCH:  if (mem_ready) ir <= mem_rdata[31:0];
        S_DECODE: begin
          a_reg   <= rf_a;
          b_reg   <= rf_b;
          imm_reg <= imm_sel;
        end
        S_EXEC: begin
          alu_out <= alu_result;
          if (is_branch && !(taken && misaligned)) begin
            pc      <= taken ? alu_result : pc_plus4;
            instret <= instret + 32'd1;
          end
        end
        S_MEM: begin
          if (mem_ready && is_load) mdr <= mem_rdata;
          if (mem_ready && is_store) begin
            pc      <= pc_plus4;
            instret <= instret + 32'd1;
          end
        end
        S_WB: begin
          if (rd != 5'd0) rf[rd] <= is_load ? mdr : alu_out;
          pc      <= pc_plus4;
          instret <= instret + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
